// File: rtl/pulse_train_gen.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : pulse_train_gen
// Purpose  : Programmable burst generator (pulses per set, sets, high/low/gap
//            times) with tick prescaler, continuous-repeat mode and abort.
// Revision : 1.0 - initial release
// ============================================================================
module pulse_train_gen #(
    parameter int TICK_DIV = 12500000,
    parameter int CNT_W    = 3,
    parameter int TIME_W   = 8
) (
    input  logic              CLOCK_50,
    input  logic              RESET,
    input  logic              start,
    input  logic              abort,
    input  logic              repeat_mode,
    input  logic [CNT_W-1:0]  pulses,
    input  logic [CNT_W-1:0]  sets,
    input  logic [TIME_W-1:0] high_len,
    input  logic [TIME_W-1:0] low_len,
    input  logic [TIME_W-1:0] gap_len,
    output logic              pulse_out,
    output logic              busy,
    output logic              done,
    output logic              aborted,
    output logic [CNT_W-1:0]  pulse_idx,
    output logic [CNT_W-1:0]  set_idx
);

    localparam int              PS_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PS_W-1:0] PS_MAX = PS_W'(TICK_DIV - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_HIGH = 2'd1,
        S_LOW  = 2'd2,
        S_GAP  = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [PS_W-1:0]     ps_q, ps_d;
    logic [TIME_W-1:0]   tmr_q, tmr_d;
    logic [CNT_W-1:0]    pidx_q, pidx_d;
    logic [CNT_W-1:0]    sidx_q, sidx_d;
    logic [CNT_W-1:0]    pulses_q, pulses_d;
    logic [CNT_W-1:0]    sets_q, sets_d;
    logic [TIME_W-1:0]   high_q, high_d;
    logic [TIME_W-1:0]   low_q, low_d;
    logic [TIME_W-1:0]   gap_q, gap_d;
    logic                pulse_out_q, pulse_out_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                aborted_q, aborted_d;

    logic                tick;
    logic                expire;
    logic [TIME_W-1:0]   phase_len;

    always_comb begin
        state_d     = state_q;
        ps_d        = ps_q;
        tmr_d       = tmr_q;
        pidx_d      = pidx_q;
        sidx_d      = sidx_q;
        pulses_d    = pulses_q;
        sets_d      = sets_q;
        high_d      = high_q;
        low_d       = low_q;
        gap_d       = gap_q;
        done_d      = 1'b0;
        aborted_d   = 1'b0;
        tick        = (ps_q == PS_MAX);

        case (state_q)
            S_HIGH:  phase_len = high_q;
            S_LOW:   phase_len = low_q;
            S_GAP:   phase_len = gap_q;
            default: phase_len = '0;
        endcase
        expire = tick && (tmr_q == phase_len);

        if (state_q == S_IDLE) begin
            ps_d  = '0;
            tmr_d = '0;
            if (start && !abort) begin
                pulses_d = pulses;
                sets_d   = sets;
                high_d   = high_len;
                low_d    = low_len;
                gap_d    = gap_len;
                pidx_d   = '0;
                sidx_d   = '0;
                state_d  = S_HIGH;
            end
        end else if (abort) begin
            state_d   = S_IDLE;
            aborted_d = 1'b1;
            ps_d      = '0;
            tmr_d     = '0;
        end else begin
            ps_d = tick ? '0 : ps_q + 1'b1;
            if (expire) begin
                tmr_d = '0;
            end else if (tick) begin
                tmr_d = tmr_q + 1'b1;
            end
            if (expire) begin
                case (state_q)
                    S_HIGH: begin
                        if (pidx_q != pulses_q) begin
                            state_d = S_LOW;
                            pidx_d  = pidx_q + 1'b1;
                        end else if (sidx_q != sets_q) begin
                            state_d = S_GAP;
                            pidx_d  = '0;
                            sidx_d  = sidx_q + 1'b1;
                        end else if (repeat_mode) begin
                            // repeat_mode is deliberately live, not latched
                            state_d = S_GAP;
                            pidx_d  = '0;
                            sidx_d  = '0;
                        end else begin
                            state_d = S_IDLE;
                            done_d  = 1'b1;
                        end
                    end
                    default: state_d = S_HIGH;
                endcase
            end
        end

        pulse_out_d = (state_d == S_HIGH);
        busy_d      = (state_d != S_IDLE);
    end

    always_ff @(posedge CLOCK_50 or posedge RESET) begin
        if (RESET) begin
            state_q     <= S_IDLE;
            ps_q        <= '0;
            tmr_q       <= '0;
            pidx_q      <= '0;
            sidx_q      <= '0;
            pulses_q    <= '0;
            sets_q      <= '0;
            high_q      <= '0;
            low_q       <= '0;
            gap_q       <= '0;
            pulse_out_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            aborted_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            ps_q        <= ps_d;
            tmr_q       <= tmr_d;
            pidx_q      <= pidx_d;
            sidx_q      <= sidx_d;
            pulses_q    <= pulses_d;
            sets_q      <= sets_d;
            high_q      <= high_d;
            low_q       <= low_d;
            gap_q       <= gap_d;
            pulse_out_q <= pulse_out_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            aborted_q   <= aborted_d;
        end
    end

    assign pulse_out = pulse_out_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign aborted   = aborted_q;
    assign pulse_idx = pidx_q;
    assign set_idx   = sidx_q;

endmodule
`default_nettype wire

// File: tb/tb_pulse_train_gen.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_pulse_train_gen
// Purpose  : Self-checking bench; two instances (tick every cycle, tick every
//            4 cycles) checked against an expanded-waveform reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pulse_train_gen;

    logic       clk = 1'b0;
    logic       rst, start, abort, rep;
    logic [2:0] pulses, sets;
    logic [7:0] hl, ll, gl;
    logic [1:0] po, bz, dn, ab;
    logic [2:0] pi0, pi1, si0, si1;

    always #5 clk = ~clk;

    pulse_train_gen #(.TICK_DIV(1), .CNT_W(3), .TIME_W(8)) u_dut1 (
        .CLOCK_50(clk), .RESET(rst), .start(start), .abort(abort),
        .repeat_mode(rep), .pulses(pulses), .sets(sets), .high_len(hl),
        .low_len(ll), .gap_len(gl), .pulse_out(po[0]), .busy(bz[0]),
        .done(dn[0]), .aborted(ab[0]), .pulse_idx(pi0), .set_idx(si0)
    );

    pulse_train_gen #(.TICK_DIV(4), .CNT_W(3), .TIME_W(8)) u_dut4 (
        .CLOCK_50(clk), .RESET(rst), .start(start), .abort(abort),
        .repeat_mode(rep), .pulses(pulses), .sets(sets), .high_len(hl),
        .low_len(ll), .gap_len(gl), .pulse_out(po[1]), .busy(bz[1]),
        .done(dn[1]), .aborted(ab[1]), .pulse_idx(pi1), .set_idx(si1)
    );

    typedef struct packed {
        logic       po;
        logic       bz;
        logic       dn;
        logic       ab;
        logic [2:0] pi;
        logic [2:0] si;
    } obs_t;

    typedef struct {
        int sel;
        int p, s, h, l, g;
    } cfg_t;

    typedef struct {
        cfg_t c;
        int   exp_busy;
        int   exp_edges;
        int   exp_maxsi;
    } vec_t;

    int   checks = 0;
    int   errors = 0;
    obs_t exp_q[$];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic obs_t rd(input int sel);
        obs_t o;
        if (sel == 0) o = {po[0], bz[0], dn[0], ab[0], pi0, si0};
        else          o = {po[1], bz[1], dn[1], ab[1], pi1, si1};
        return o;
    endfunction

    function automatic obs_t mk(input logic p_o, input logic b, input logic d,
                                input int pidx, input int sidx);
        obs_t o;
        o = {p_o, b, d, 1'b0, 3'(pidx), 3'(sidx)};
        return o;
    endfunction

    // Expected cycle-by-cycle waveform of `passes` back-to-back passes through
    // all sets (joined by gaps), ending with the done cycle.
    task automatic build(input cfg_t c, input int passes);
        int div;
        div = (c.sel == 0) ? 1 : 4;
        for (int n = 0; n < passes; n++) begin
            for (int s = 0; s <= c.s; s++) begin
                for (int p = 0; p <= c.p; p++) begin
                    repeat ((c.h + 1) * div) exp_q.push_back(mk(1, 1, 0, p, s));
                    if (p < c.p)
                        repeat ((c.l + 1) * div) exp_q.push_back(mk(0, 1, 0, p + 1, s));
                end
                if (s < c.s)
                    repeat ((c.g + 1) * div) exp_q.push_back(mk(0, 1, 0, 0, s + 1));
                else if (n < passes - 1)
                    repeat ((c.g + 1) * div) exp_q.push_back(mk(0, 1, 0, 0, 0));
            end
        end
        exp_q.push_back(mk(0, 0, 1, c.p, c.s));
    endtask

    task automatic apply_cfg(input cfg_t c);
        pulses = 3'(c.p);
        sets   = 3'(c.s);
        hl     = 8'(c.h);
        ll     = 8'(c.l);
        gl     = 8'(c.g);
    endtask

    task automatic idle_both();
        @(negedge clk);
        start = 1'b0;
        abort = 1'b1;
        rep   = 1'b0;
        @(negedge clk);
        abort = 1'b0;
    endtask

    task automatic run_wave(input cfg_t c, input bit scramble, input string name,
                            output int busy_n, output int edges, output int dones,
                            output int maxsi);
        obs_t o;
        int   mism;
        logic prev;
        exp_q.delete();
        build(c, 1);
        apply_cfg(c);
        start  = 1'b1;
        mism   = 0;
        prev   = 1'b0;
        busy_n = 0;
        edges  = 0;
        dones  = 0;
        maxsi  = 0;
        for (int i = 0; i <= exp_q.size(); i++) begin
            @(negedge clk);
            o = rd(c.sel);
            if (i < exp_q.size() && o != exp_q[i]) mism++;
            if (o.bz) busy_n++;
            if (o.dn) dones++;
            if (o.po && !prev) edges++;
            if (int'(o.si) > maxsi) maxsi = int'(o.si);
            prev = o.po;
            if (scramble && i < exp_q.size() - 1) begin
                start  = 1'($urandom);
                pulses = 3'($urandom);
                sets   = 3'($urandom);
                hl     = 8'($urandom);
                ll     = 8'($urandom);
                gl     = 8'($urandom);
            end else begin
                start = 1'b0;
            end
        end
        chk({name, ".wave_mismatch_cycles"}, mism, 0);
    endtask

    vec_t tbl[7];
    cfg_t c;
    obs_t o;
    int   busy_n, edges, dones, maxsi, mism, q1, abts, div, exp_busy;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; start = 1'b0; abort = 1'b0; rep = 1'b0;
        pulses = '0; sets = '0; hl = '0; ll = '0; gl = '0;
        repeat (2) @(negedge clk);
        chk("reset.dut1", int'(rd(0)), 0);
        chk("reset.dut4", int'(rd(1)), 0);
        rst = 1'b0;

        // {sel, pulses, sets, high, low, gap}, busy cycles, rising edges, max set_idx
        tbl[0] = '{'{0, 1, 0, 0, 0, 0},   3,  2, 0};
        tbl[1] = '{'{1, 2, 1, 1, 0, 2},  76,  6, 1};
        tbl[2] = '{'{0, 7, 7, 0, 0, 0}, 127, 64, 7};
        tbl[3] = '{'{0, 0, 0, 0, 0, 0},   1,  1, 0};
        tbl[4] = '{'{1, 0, 2, 2, 5, 1},  52,  3, 2};
        tbl[5] = '{'{0, 3, 0, 0, 2, 9},  13,  4, 0};
        tbl[6] = '{'{1, 0, 0, 0, 0, 0},   4,  1, 0};

        for (int i = 0; i < 7; i++) begin
            idle_both();
            run_wave(tbl[i].c, (i % 2) == 1, $sformatf("vec%0d", i),
                     busy_n, edges, dones, maxsi);
            chk($sformatf("vec%0d.busy_cycles", i), busy_n, tbl[i].exp_busy);
            chk($sformatf("vec%0d.rising_edges", i), edges, tbl[i].exp_edges);
            chk($sformatf("vec%0d.done_count", i), dones, 1);
            chk($sformatf("vec%0d.max_set_idx", i), maxsi, tbl[i].exp_maxsi);
        end

        for (int k = 0; k < 12; k++) begin
            c.sel = int'($urandom_range(1, 0));
            c.p   = int'($urandom_range(7, 0));
            c.s   = int'($urandom_range(7, 0));
            c.h   = int'($urandom_range(2, 0));
            c.l   = int'($urandom_range(2, 0));
            c.g   = int'($urandom_range(2, 0));
            div      = (c.sel == 0) ? 1 : 4;
            exp_busy = div * ((c.s + 1) * ((c.p + 1) * (c.h + 1) + c.p * (c.l + 1))
                              + c.s * (c.g + 1));
            idle_both();
            run_wave(c, 1'b1, $sformatf("rand%0d", k), busy_n, edges, dones, maxsi);
            chk($sformatf("rand%0d.busy_cycles", k), busy_n, exp_busy);
            chk($sformatf("rand%0d.done_count", k), dones, 1);
        end

        // Repeat mode, cleared during set 1 of the second pass
        c = '{1, 2, 1, 1, 0, 2};
        idle_both();
        exp_q.delete();
        build(c, 2);
        apply_cfg(c);
        rep = 1'b1;
        start = 1'b1;
        mism = 0; dones = 0; edges = 0; o = '0;
        for (int i = 0; i < exp_q.size(); i++) begin
            logic prev;
            prev = o.po;
            @(negedge clk);
            o = rd(1);
            if (o != exp_q[i]) mism++;
            if (o.dn) dones++;
            if (o.po && !prev) edges++;
            start = 1'b0;
            if (i == 139) rep = 1'b0;
        end
        chk("repeat.wave_mismatch_cycles", mism, 0);
        chk("repeat.done_count", dones, 1);
        chk("repeat.rising_edges", edges, 12);

        // Abort sampled at cycle 30
        idle_both();
        exp_q.delete();
        build(c, 1);
        apply_cfg(c);
        start = 1'b1;
        mism = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (rd(1) != exp_q[i]) mism++;
            start = 1'b0;
            if (i == 29) abort = 1'b1;
        end
        chk("abort.pre_wave_mismatch_cycles", mism, 0);
        @(negedge clk);
        abort = 1'b0;
        o = rd(1);
        chk("abort.po_bz_dn_ab", int'({o.po, o.bz, o.dn, o.ab}), 4'b0001);
        chk("abort.pulse_idx_hold", int'(o.pi), int'(exp_q[29].pi));
        chk("abort.set_idx_hold", int'(o.si), int'(exp_q[29].si));
        dones = 0; abts = 0; busy_n = 0;
        repeat (100) begin
            @(negedge clk);
            o = rd(1);
            if (o.dn) dones++;
            if (o.ab) abts++;
            if (o.bz) busy_n++;
        end
        chk("abort.later_done", dones, 0);
        chk("abort.later_aborted", abts, 0);
        chk("abort.later_busy", busy_n, 0);

        // start held high across a whole run restarts right after done
        c = '{0, 1, 0, 0, 0, 0};
        idle_both();
        exp_q.delete();
        build(c, 1);
        q1 = exp_q.size();
        build(c, 1);
        apply_cfg(c);
        start = 1'b1;
        mism = 0; dones = 0;
        for (int i = 0; i < exp_q.size(); i++) begin
            @(negedge clk);
            o = rd(0);
            if (o != exp_q[i]) mism++;
            if (o.dn) dones++;
            if (i == q1) start = 1'b0;
        end
        chk("hold_start.wave_mismatch_cycles", mism, 0);
        chk("hold_start.done_count", dones, 2);

        // start and abort together in IDLE
        idle_both();
        apply_cfg(c);
        start = 1'b1;
        abort = 1'b1;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        chk("start_abort_idle.dut1", int'({rd(0).po, rd(0).bz, rd(0).ab}), 0);
        chk("start_abort_idle.dut4", int'({rd(1).po, rd(1).bz, rd(1).ab}), 0);
        @(negedge clk);
        chk("start_abort_idle.busy_after", int'(bz), 0);

        // Asynchronous reset in the middle of a HIGH phase of set 1
        c = '{1, 2, 1, 1, 0, 2};
        idle_both();
        exp_q.delete();
        build(c, 1);
        apply_cfg(c);
        start = 1'b1;
        mism = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (rd(1) != exp_q[i]) mism++;
            start = 1'b0;
        end
        chk("async_reset.pre_wave_mismatch_cycles", mism, 0);
        chk("async_reset.pre_state", int'({rd(1).po, rd(1).si}), int'({exp_q[49].po, exp_q[49].si}));
        #2 rst = 1'b1;
        #1;
        o = rd(1);
        chk("async_reset.immediate", int'({o.po, o.bz, o.pi, o.si}), 0);
        @(negedge clk);
        rst = 1'b0;
        dones = 0; abts = 0; busy_n = 0;
        repeat (20) begin
            @(negedge clk);
            if (|dn) dones++;
            if (|ab) abts++;
            if (|bz) busy_n++;
        end
        chk("async_reset.no_done", dones, 0);
        chk("async_reset.no_aborted", abts, 0);
        chk("async_reset.no_busy", busy_n, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pulse_train_gen.md
Name: pulse_train_gen

Overview:
Parametrised pulse-train generator, the successor to the fixed switch-driven pulse/set sequencer. It emits bursts of pulses: pulse count per set, set count, high time, low time and inter-set gap are all programmable, and it adds a continuous-repeat mode and abort. Timing derives from an internal tick prescaler off CLOCK_50. The block sits between board switch/control logic and an LED or GPIO output.

Parameters:
TICK_DIV, 12500000, CLOCK_50 cycles per tick (>=1; 1 = tick every cycle)
CNT_W, 3, width of pulse/set count fields
TIME_W, 8, width of high/low/gap duration fields

Ports:
CLOCK_50  in  1  system clock
RESET  in  1  asynchronous, active-high reset
start  in  1  level-sampled request; honoured only in IDLE
abort  in  1  synchronous stop; wins over everything except RESET
repeat_mode  in  1  1 = restart at set 0 after last set instead of finishing
pulses  in  CNT_W  pulses per set minus 1
sets  in  CNT_W  sets per run minus 1
high_len  in  TIME_W  high time in ticks minus 1
low_len  in  TIME_W  intra-set low time in ticks minus 1
gap_len  in  TIME_W  inter-set low time in ticks minus 1
pulse_out  out  1  generated waveform
busy  out  1  high in HIGH/LOW/GAP
done  out  1  one-cycle strobe on normal completion
aborted  out  1  one-cycle strobe on abort of an active run
pulse_idx  out  CNT_W  index of current pulse within set
set_idx  out  CNT_W  index of current set

Behaviour:
- RESET (async): state=IDLE; pulse_out, busy, done, aborted = 0; pulse_idx, set_idx, prescaler, phase timer = 0.
- The block latches all config inputs (pulses, sets, *_len, repeat_mode) on an accepted start. Later input changes have no effect until the next start. repeat_mode is the only exception: it is resampled live, so clearing it ends the run after the current last set.
- Prescaler counts 0..TICK_DIV-1 and produces a tick on wrap. It is cleared on an accepted start, so every phase lasts exactly (len+1)*TICK_DIV cycles.
- Registered outputs: pulse_out = 1 iff state==HIGH; busy = 1 iff state in {HIGH, LOW, GAP}.
- States:
  IDLE: on start=1 and abort=0, latch config, clear indices, go to HIGH next cycle. pulse_out is high in the first cycle after start is sampled.
  HIGH: lasts (high_len+1) ticks. At expiry:
    - pulse_idx != pulses_l: go to LOW, pulse_idx++.
    - else if set_idx != sets_l: go to GAP, pulse_idx=0, set_idx++.
    - else if repeat_mode: go to GAP, pulse_idx=0, set_idx=0.
    - else: go to IDLE with done=1 for that first IDLE cycle.
  LOW: lasts (low_len+1) ticks, then HIGH.
  GAP: lasts (gap_len+1) ticks, then HIGH.
- Abort:
  - abort=1 in HIGH/LOW/GAP: go to IDLE next cycle; pulse_out=0 and aborted=1 for that cycle; no done; indices hold their last value.
  - abort in IDLE is a no-op and also blocks a simultaneous start.
- start while busy is ignored (no restart, no latch).
- pulses=0 gives 1 pulse per set; sets=0 gives 1 set. All-zero config gives a single pulse of one tick.
- Index comparisons are equality on CNT_W bits, so the max field value yields 2^CNT_W pulses/sets with no wrap error.
- Total run length (non-repeat), in ticks: S*(P*(H+1) + (P-1)*(L+1)) + (S-1)*(G+1), where P=pulses+1, S=sets+1, H/L/G = the len fields.
- RESET mid-run returns to the reset state immediately; no done or aborted strobe.

Test Plan:
1. TICK_DIV=1, pulses=1, sets=0, all len=0; start pulsed at cycle 0 -> pulse_out=1,0,1 on cycles 1-3; cycle 4 pulse_out=0, done=1, busy=0.
2. TICK_DIV=4, pulses=2, sets=1, high_len=1, low_len=0, gap_len=2 -> 6 rising edges; each high 8 cycles, intra-set low 4, gap 12; busy high exactly 76 cycles; single done.
3. Config from test 2 plus repeat_mode=1; clear repeat_mode during set 1 -> run completes at the end of set 1, then done. Separately, abort at cycle 30 -> pulse_out=0 at cycle 31, aborted=1 for one cycle, no done.
4. start held high across an entire run -> new run begins the cycle after done. start re-pulsed mid-run -> ignored; waveform unchanged. Changing pulses mid-run -> no effect.
5. pulses=7, sets=7, CNT_W=3, all len=0, TICK_DIV=1 -> exactly 64 pulses, set_idx reaches 7, done once. Simultaneous start+abort in IDLE -> stays IDLE.
6. RESET asserted asynchronously mid-HIGH -> pulse_out, busy and indices go to 0 without waiting for a clock edge; no strobe follows.
